// File: rtl/wbm_arb.sv
// wbm_arb: three-master round-robin Wishbone arbiter. The grant is held for the whole cycle and followed by one park cycle.
// Optional bus watchdog: define WBM_ARB_WATCHDOG_EN.
module wbm_arb #(
  parameter int TMO_W = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_cab_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_dat64_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m0_dat64_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic        m1_cab_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_dat64_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic [31:0] m1_dat_o,
  output logic [31:0] m1_dat64_o,
  input  logic        m2_cyc_i,
  input  logic        m2_stb_i,
  input  logic        m2_we_i,
  input  logic        m2_cab_i,
  input  logic [3:0]  m2_sel_i,
  input  logic [31:0] m2_adr_i,
  input  logic [31:0] m2_dat_i,
  input  logic [31:0] m2_dat64_i,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  output logic        m2_rty_o,
  output logic [31:0] m2_dat_o,
  output logic [31:0] m2_dat64_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic        s_cab_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_dat64_o,
  input  logic [31:0] s_dat_i,
  input  logic [31:0] s_dat64_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [2:0]  gnt_o,
  output logic        tmo_o
);

  typedef enum logic [1:0] {S_IDLE, S_GNT, S_PARK} state_t;

  state_t      r_state;
  logic [2:0]  r_gnt;
  logic [1:0]  r_gidx;
  logic [1:0]  r_last;

  logic [2:0]  w_cyc, w_stb, w_we, w_cab;
  logic [3:0]  w_sel   [3];
  logic [31:0] w_adr   [3];
  logic [31:0] w_dat   [3];
  logic [31:0] w_dat64 [3];
  logic [2:0]  w_ack, w_err, w_rty;
  logic [1:0]  w_ord   [3];
  logic [1:0]  w_win;
  logic        w_act, w_gcyc, w_kill, w_tmo;

  assign w_cyc = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign w_stb = {m2_stb_i, m1_stb_i, m0_stb_i};
  assign w_we  = {m2_we_i,  m1_we_i,  m0_we_i};
  assign w_cab = {m2_cab_i, m1_cab_i, m0_cab_i};
  assign w_sel[0]   = m0_sel_i;
  assign w_sel[1]   = m1_sel_i;
  assign w_sel[2]   = m2_sel_i;
  assign w_adr[0]   = m0_adr_i;
  assign w_adr[1]   = m1_adr_i;
  assign w_adr[2]   = m2_adr_i;
  assign w_dat[0]   = m0_dat_i;
  assign w_dat[1]   = m1_dat_i;
  assign w_dat[2]   = m2_dat_i;
  assign w_dat64[0] = m0_dat64_i;
  assign w_dat64[1] = m1_dat64_i;
  assign w_dat64[2] = m2_dat64_i;

  // Search order starts at the master after the last one served.
  always_comb begin
    case (r_last)
      2'd0:    w_ord = '{2'd1, 2'd2, 2'd0};
      2'd1:    w_ord = '{2'd2, 2'd0, 2'd1};
      default: w_ord = '{2'd0, 2'd1, 2'd2};
    endcase
    w_win = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (w_cyc[w_ord[k]]) w_win = w_ord[k];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= 3'b000;
      r_gidx  <= 2'd0;
      r_last  <= 2'd2;
    end else begin
      case (r_state)
        S_IDLE: if (|w_cyc) begin
          r_gnt   <= 3'b001 << w_win;
          r_gidx  <= w_win;
          r_state <= S_GNT;
        end
        S_GNT: if (!w_cyc[r_gidx]) begin
          r_last  <= r_gidx;
          r_gnt   <= 3'b000;
          r_state <= S_PARK;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_act  = (r_state == S_GNT);
  assign w_gcyc = w_act & w_cyc[r_gidx];

  assign s_cyc_o   = w_gcyc & ~w_kill;
  assign s_stb_o   = w_gcyc & w_stb[r_gidx] & ~w_kill;
  assign s_we_o    = w_act & w_we[r_gidx];
  assign s_cab_o   = w_act & w_cab[r_gidx];
  assign s_sel_o   = w_act ? w_sel[r_gidx]   : 4'h0;
  assign s_adr_o   = w_act ? w_adr[r_gidx]   : 32'h0;
  assign s_dat_o   = w_act ? w_dat[r_gidx]   : 32'h0;
  assign s_dat64_o = w_act ? w_dat64[r_gidx] : 32'h0;
  assign gnt_o     = r_gnt;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_resp
      assign w_ack[gi] = w_act & r_gnt[gi] & s_ack_i;
      assign w_rty[gi] = w_act & r_gnt[gi] & s_rty_i;
      assign w_err[gi] = r_gnt[gi] & ((w_act & s_err_i) | w_tmo);
    end
  endgenerate

  assign m0_ack_o = w_ack[0];
  assign m1_ack_o = w_ack[1];
  assign m2_ack_o = w_ack[2];
  assign m0_err_o = w_err[0];
  assign m1_err_o = w_err[1];
  assign m2_err_o = w_err[2];
  assign m0_rty_o = w_rty[0];
  assign m1_rty_o = w_rty[1];
  assign m2_rty_o = w_rty[2];
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign m2_dat_o   = s_dat_i;
  assign m0_dat64_o = s_dat64_i;
  assign m1_dat64_o = s_dat64_i;
  assign m2_dat64_o = s_dat64_i;

`ifdef WBM_ARB_WATCHDOG_EN
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo;
  logic             r_kill;

  // Fire on the increment that lands on all-ones; the slave stays cut off until the master gives up cyc.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tmo_cnt <= '0;
      r_tmo     <= 1'b0;
      r_kill    <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      if (!w_act || s_ack_i || s_err_i || s_rty_i) begin
        r_tmo_cnt <= '0;
      end else if (s_stb_o) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
        if (r_tmo_cnt == {{(TMO_W-1){1'b1}}, 1'b0}) begin
          r_tmo  <= 1'b1;
          r_kill <= 1'b1;
        end
      end
      if (!w_gcyc) r_kill <= 1'b0;
    end
  end

  assign w_tmo  = r_tmo;
  assign w_kill = r_kill;
  assign tmo_o  = r_tmo;
`else
  assign w_tmo  = 1'b0;
  assign w_kill = 1'b0;
  // TMO_W only sizes the watchdog, so this build reports a constant low.
  assign tmo_o  = (TMO_W == 0);
`endif

endmodule

// File: doc/wbm_arb.md
WBM_ARB -- requirements
Module: wbm_arb

Interface
REQ-001 Parameter TMO_W, default 8: width of the bus-watchdog counter; the timeout limit is 2^TMO_W-1 cycles.
REQ-002 wb_clk_i  in  1  single clock; all logic rising-edge.
REQ-003 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 mN_cyc_i, mN_stb_i, mN_we_i, mN_cab_i  in  1 each  (N=0..2) Wishbone master N control.
REQ-005 mN_sel_i  in  4; mN_adr_i  in  32; mN_dat_i, mN_dat64_i  in  32  master N select/address/write data.
REQ-006 mN_ack_o, mN_err_o, mN_rty_o  out  1  master N termination.
REQ-007 mN_dat_o, mN_dat64_o  out  32  master N read data.
REQ-008 s_cyc_o, s_stb_o, s_we_o, s_cab_o  out  1; s_sel_o  out  4; s_adr_o  out  32; s_dat_o, s_dat64_o  out  32  shared slave port.
REQ-009 s_dat_i, s_dat64_i  in  32; s_ack_i, s_err_i, s_rty_i  in  1  slave responses.
REQ-010 gnt_o  out  3  one-hot current grant (debug); tmo_o  out  1  watchdog-fired pulse.

Function
REQ-011 Port usage: master 0 = descriptor fetch/ctl writeback; masters 1-2 = data engines.
REQ-012 FSM states: S_IDLE, S_GNT, S_PARK.
REQ-013 S_IDLE: if any mN_cyc_i is high, the block SHALL pick the winner round-robin starting at (last+1) mod 3, register a one-hot grant, and enter S_GNT on the next edge.
REQ-014 Request-to-s_cyc_o latency: exactly 1 cycle, with zero cycles spent in S_IDLE beyond the arbitration cycle.
REQ-015 S_GNT: s_* outputs SHALL be combinational copies of the granted master's inputs; s_dat_i/s_dat64_i SHALL be broadcast to all mN_dat_o; ack/err/rty SHALL be routed only to the granted master, and non-granted masters SHALL see 0.
REQ-016 Grant is locked for the whole cycle: arbitration SHALL NOT occur while the granted mN_cyc_i stays high, regardless of stb or other requests (burst integrity for cab bursts).
REQ-017 Granted mN_cyc_i falling SHALL cause a transition to S_PARK, update last to the granted index, and drive s_cyc_o/s_stb_o to 0 in that same cycle.
REQ-018 S_PARK lasts exactly 1 cycle with all s_* controls low, then returns to S_IDLE (mandatory bus turnaround).
REQ-019 Multiple simultaneous requests SHALL be served in rotation; no master SHALL wait more than 2 other complete grants.
REQ-020 s_err_i and s_rty_i SHALL be passed through without ending the grant; only cyc deassertion ends it.
REQ-021 When no grant is active, s_adr_o, s_dat_o, s_dat64_o and s_sel_o SHALL be 0.

Reset
REQ-022 Under wb_rst_i, state = S_IDLE, grant = 000, and last = 2 (so master 0 has first priority); the watchdog counter is cleared and tmo_o = 0.
REQ-023 All mN_ack/err/rty_o and s_cyc_o/s_stb_o SHALL be 0 in the cycle after reset is sampled, including when reset lands mid-grant.

Configuration
REQ-024 Macro WBM_ARB_WATCHDOG_EN.
REQ-025 With the macro defined, a TMO_W-bit counter SHALL clear on each s_ack_i/s_err_i/s_rty_i or grant change and increment every S_GNT cycle in which s_stb_o is high. When it reaches all-ones, the block SHALL pulse mN_err_o of the granted master and tmo_o for 1 cycle, and force s_cyc_o low until that master drops cyc.
REQ-026 Without the macro, there is no counter, tmo_o is tied to 0, and a grant can be held indefinitely.

Verification
REQ-027 After reset, m0/m1/m2 assert cyc in the same cycle -> grants in the order 0,1,2; each grant is followed by 1 S_PARK cycle, and s_cyc_o shows 3 separate cycles.
REQ-028 m0 runs a 4-beat cab read; m1 requests at beat 2 -> m1 gnt_o rises only after m0 cyc falls plus 1 park cycle; m1 sees no ack during m0's burst.
REQ-029 m1 is granted with s_dat_i=32'hA5A5_0001 and ack -> m1_dat_o=32'hA5A5_0001, m1_ack_o=1, and m0_ack_o=m2_ack_o=0.
REQ-030 Slave asserts s_rty_i for 2 cycles, then ack -> the grant is held throughout, and the retry and ack are delivered to the same master.
REQ-031 wb_rst_i is asserted in the middle of an m2 grant -> next cycle gnt_o=000 and s_cyc_o=0; a subsequent m0 and m2 request is granted to m0 first.
REQ-032 WBM_ARB_WATCHDOG_EN defined, TMO_W=4, and the slave never acks -> m_err_o and tmo_o pulse after 15 stb cycles, then s_cyc_o goes to 0.
